// File: rtl/seq_det_pkg.sv
// ----------------------------------------------------------------------------
// seq_det_pkg
//   Shared definitions for the configurable serial pattern detector.
//   - state_e  : controller FSM encoding (IDLE / RUN / DONE)
//   - DEF_PAT  : pattern loaded at reset (0110, right-aligned)
//   - DEF_LEN  : pattern length loaded at reset
// ----------------------------------------------------------------------------
package seq_det_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [7:0]  DEF_PAT = 8'h06;
   localparam int unsigned DEF_LEN = 4;

endpackage : seq_det_pkg

// File: rtl/seq_shift_cmp.sv
// ----------------------------------------------------------------------------
// seq_shift_cmp
//   History shift register, fill counter and length-masked pattern comparator.
//   The comparison is made against the post-shift history so that hit is
//   valid in the same cycle as the completing bit; the owner registers it.
// Ports
//   clk       in   1      rising-edge clock
//   reset     in   1      synchronous, active-high
//   shift_en  in   1      accept 'in' as a stream bit this cycle
//   flush     in   1      clear history and fill (start of a run)
//   in        in   1      serial data bit
//   pattern   in   PAT_W  reference pattern, right-aligned
//   len       in   LEN_W  active pattern length (1..PAT_W)
//   overlap   in   1      1 = keep fill after a hit, 0 = restart fill
//   hit       out  1      completing bit matched (combinational)
// ----------------------------------------------------------------------------
module seq_shift_cmp #(
   parameter int unsigned PAT_W = 8,
   parameter int unsigned LEN_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             shift_en,
   input  logic             flush,
   input  logic             in,
   input  logic [PAT_W-1:0] pattern,
   input  logic [LEN_W-1:0] len,
   input  logic             overlap,
   output logic             hit
);

   logic [PAT_W-1:0] hist_q, hist_d;
   logic [LEN_W-1:0] fill_q, fill_d;

   logic [PAT_W-1:0] shifted;
   logic [PAT_W-1:0] mask;
   logic [LEN_W-1:0] fill_inc;
   logic             cmp_ok;

   always_comb begin
      shifted = {hist_q[PAT_W-2:0], in};

      // Only the low 'len' bits take part in the comparison.
      mask = '0;
      for (int unsigned i = 0; i < PAT_W; i++) begin
         mask[i] = (i < 32'(len));
      end

      cmp_ok = (((shifted ^ pattern) & mask) == '0);

      // Fill saturates at len; it only tells us whether enough bits arrived.
      fill_inc = (fill_q >= len) ? len : fill_q + 1'b1;
   end

   always_comb begin
      hist_d = hist_q;
      fill_d = fill_q;
      hit    = 1'b0;
      if (flush) begin
         hist_d = '0;
         fill_d = '0;
      end else if (shift_en) begin
         hist_d = shifted;
         fill_d = fill_inc;
         hit    = (fill_inc >= len) && cmp_ok;
         // Non-overlap: stale history is ignored until len new bits arrive.
         if (hit && !overlap) begin
            fill_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hist_q <= '0;
         fill_q <= '0;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
      end
   end

endmodule : seq_shift_cmp

// File: rtl/seq_detect_ctrl.sv
// ----------------------------------------------------------------------------
// seq_detect_ctrl
//   Programmable controller around a serial bit-pattern detector.
//   The host loads pattern/length/overlap/target while idle, starts a run,
//   and the block counts matches on the qualified serial stream, entering
//   DONE when the target count is reached (target 0 = run until abort).
// Ports
//   clk          in   1      single clock, rising edge
//   reset        in   1      synchronous, active-high
//   cfg_we       in   1      latch cfg_* (honoured in IDLE/DONE only)
//   cfg_pattern  in   PAT_W  pattern; first bit = [len-1], last = [0]
//   cfg_len      in   LEN_W  active pattern length, legal 1..PAT_W
//   cfg_overlap  in   1      1 = overlapping matches allowed
//   cfg_target   in   CNT_W  matches to reach done; 0 = unlimited
//   start        in   1      begin a run (IDLE/DONE only)
//   abort        in   1      end a run, return to IDLE
//   in_valid     in   1      'in' carries a stream bit this cycle
//   in           in   1      serial data bit
//   busy         out  1      high while running
//   done         out  1      level, high in DONE
//   match        out  1      one-cycle pulse, cycle after the completing bit
//   match_count  out  CNT_W  matches this run, saturating
//   cfg_err      out  1      sticky illegal-length flag
// ----------------------------------------------------------------------------
module seq_detect_ctrl
   import seq_det_pkg::*;
#(
   parameter int unsigned      PAT_W   = 8,
   parameter int unsigned      LEN_W   = 4,
   parameter int unsigned      CNT_W   = 8,
   parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(seq_det_pkg::DEF_PAT),
   parameter logic [LEN_W-1:0] DEF_LEN = LEN_W'(seq_det_pkg::DEF_LEN)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_we,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             cfg_overlap,
   input  logic [CNT_W-1:0] cfg_target,
   input  logic             start,
   input  logic             abort,
   input  logic             in_valid,
   input  logic             in,
   output logic             busy,
   output logic             done,
   output logic             match,
   output logic [CNT_W-1:0] match_count,
   output logic             cfg_err
);

   state_e           state_q;
   logic             busy_q, done_q, match_q, cfg_err_q;
   logic [CNT_W-1:0] count_q;

   logic [PAT_W-1:0] pat_q;
   logic [LEN_W-1:0] len_q;
   logic             ovl_q;
   logic [CNT_W-1:0] tgt_q;

   logic             len_ok;
   logic             launch;
   logic             shift_en;
   logic             hit;
   logic [CNT_W-1:0] count_d;
   logic             reach;

   always_comb begin
      len_ok   = (cfg_len != '0) && (32'(cfg_len) <= PAT_W);
      // A launch clears the detector; abort in DONE takes priority over start.
      launch   = start && (((state_q == ST_IDLE) && !cfg_err_q) ||
                           ((state_q == ST_DONE) && !abort));
      shift_en = (state_q == ST_RUN) && in_valid;
      count_d  = (&count_q) ? count_q : count_q + 1'b1;
      reach    = (tgt_q != '0) && (count_d == tgt_q);
   end

   seq_shift_cmp #(
      .PAT_W (PAT_W),
      .LEN_W (LEN_W)
   ) u_shift_cmp (
      .clk      (clk),
      .reset    (reset),
      .shift_en (shift_en),
      .flush    (launch),
      .in       (in),
      .pattern  (pat_q),
      .len      (len_q),
      .overlap  (ovl_q),
      .hit      (hit)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         match_q   <= 1'b0;
         cfg_err_q <= 1'b0;
         count_q   <= '0;
         pat_q     <= DEF_PAT;
         len_q     <= DEF_LEN;
         ovl_q     <= 1'b0;
         tgt_q     <= '0;
      end else begin
         match_q <= 1'b0;

         // Configuration is frozen while a run is in progress.
         if (cfg_we && (state_q != ST_RUN)) begin
            if (len_ok) begin
               pat_q     <= cfg_pattern;
               len_q     <= cfg_len;
               ovl_q     <= cfg_overlap;
               tgt_q     <= cfg_target;
               cfg_err_q <= 1'b0;
            end else begin
               cfg_err_q <= 1'b1;
            end
         end

         case (state_q)
            ST_IDLE: begin
               if (launch) begin
                  state_q <= ST_RUN;
                  busy_q  <= 1'b1;
                  count_q <= '0;
               end
            end
            ST_RUN: begin
               if (abort) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else if (hit) begin
                  match_q <= 1'b1;
                  count_q <= count_d;
                  if (reach) begin
                     state_q <= ST_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               if (abort) begin
                  state_q <= ST_IDLE;
                  done_q  <= 1'b0;
               end else if (launch) begin
                  state_q <= ST_RUN;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  count_q <= '0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign match       = match_q;
   assign match_count = count_q;
   assign cfg_err     = cfg_err_q;

endmodule : seq_detect_ctrl

// File: tb/tb_seq_detect_ctrl.sv
// ----------------------------------------------------------------------------
// tb_seq_detect_ctrl
//   Directed-vector bench for seq_detect_ctrl with hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_seq_detect_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       cfg_we;
   logic [7:0] cfg_pattern;
   logic [3:0] cfg_len;
   logic       cfg_overlap;
   logic [7:0] cfg_target;
   logic       start;
   logic       abort;
   logic       in_valid;
   logic       in;
   logic       busy;
   logic       done;
   logic       match;
   logic [7:0] match_count;
   logic       cfg_err;

   int n_checks = 0;
   int n_errors = 0;

   seq_detect_ctrl #(
      .PAT_W   (8),
      .LEN_W   (4),
      .CNT_W   (8),
      .DEF_PAT (8'h06),
      .DEF_LEN (4'd4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cfg_we      (cfg_we),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .cfg_target  (cfg_target),
      .start       (start),
      .abort       (abort),
      .in_valid    (in_valid),
      .in          (in),
      .busy        (busy),
      .done        (done),
      .match       (match),
      .match_count (match_count),
      .cfg_err     (cfg_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len,
                         input logic ovl, input logic [7:0] tgt);
      cfg_pattern = pat;
      cfg_len     = len;
      cfg_overlap = ovl;
      cfg_target  = tgt;
      cfg_we      = 1'b1;
      tick();
      cfg_we      = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic do_abort();
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   // One valid bit; match is checked in the cycle following the bit.
   task automatic send_bit(input logic b, input logic exp_m, input string tag);
      in_valid = 1'b1;
      in       = b;
      tick();
      check(tag, 32'(match), 32'(exp_m));
      in_valid = 1'b0;
      abort    = 1'b0;
      start    = 1'b0;
   endtask

   // Bits sent MSB first; exp[i] is the expected match after bits[i].
   task automatic run_stream(input logic [15:0] bits, input logic [15:0] exp,
                             input int n, input string tag);
      for (int i = n - 1; i >= 0; i--) begin
         send_bit(bits[i], exp[i], tag);
      end
   endtask

   // Idle cycle with in toggling: must not shift or match.
   task automatic gap_tog(input string tag);
      in_valid = 1'b0;
      in       = ~in;
      tick();
      check(tag, 32'(match), 32'd0);
   endtask

   initial begin
      reset       = 1'b1;
      cfg_we      = 1'b0;
      cfg_pattern = '0;
      cfg_len     = '0;
      cfg_overlap = 1'b0;
      cfg_target  = '0;
      start       = 1'b0;
      abort       = 1'b0;
      in_valid    = 1'b0;
      in          = 1'b0;
      tick();
      tick();
      check("rst_busy",  32'(busy),        32'd0);
      check("rst_done",  32'(done),        32'd0);
      check("rst_match", 32'(match),       32'd0);
      check("rst_count", 32'(match_count), 32'd0);
      check("rst_err",   32'(cfg_err),     32'd0);
      reset = 1'b0;
      tick();

      // 1: defaults, non-overlap 0110, matches after bits 8 and 14
      do_start();
      check("t1_busy0", 32'(busy), 32'd1);
      run_stream(16'b10010110010110, 16'b00000001000001, 14, "t1_match");
      check("t1_count", 32'(match_count), 32'd2);
      check("t1_busy1", 32'(busy), 32'd1);
      do_start();
      check("t1_start_in_run", 32'(match_count), 32'd2);
      do_abort();
      check("t1_abort_busy",  32'(busy),        32'd0);
      check("t1_abort_count", 32'(match_count), 32'd2);

      // 2: overlap vs non-overlap on 0110110
      do_start();
      check("t2_cleared", 32'(match_count), 32'd0);
      run_stream(16'b0110110, 16'b0001000, 7, "t2_novl");
      check("t2_novl_cnt", 32'(match_count), 32'd1);
      do_abort();
      do_cfg(8'h06, 4'd4, 1'b1, 8'd0);
      do_start();
      run_stream(16'b0110110, 16'b0001001, 7, "t2_ovl");
      check("t2_ovl_cnt", 32'(match_count), 32'd2);
      do_abort();

      // 3: 101, len 3, target 3, overlap
      do_cfg(8'h05, 4'd3, 1'b1, 8'd3);
      do_start();
      run_stream(16'b1010101, 16'b0010101, 7, "t3_match");
      check("t3_done",  32'(done),        32'd1);
      check("t3_busy",  32'(busy),        32'd0);
      check("t3_count", 32'(match_count), 32'd3);
      run_stream(16'b0101, 16'b0000, 4, "t3_ignored");
      check("t3_count_hold", 32'(match_count), 32'd3);
      check("t3_done_hold",  32'(done),        32'd1);
      do_abort();
      check("t3_abort_done", 32'(done), 32'd0);

      // 4: in_valid gaps with in toggling
      do_cfg(8'h06, 4'd4, 1'b0, 8'd0);
      do_start();
      send_bit(1'b0, 1'b0, "t4_b1");
      gap_tog("t4_gap");
      gap_tog("t4_gap");
      send_bit(1'b1, 1'b0, "t4_b2");
      gap_tog("t4_gap");
      gap_tog("t4_gap");
      gap_tog("t4_gap");
      send_bit(1'b1, 1'b0, "t4_b3");
      gap_tog("t4_gap");
      send_bit(1'b0, 1'b1, "t4_b4");
      for (int i = 0; i < 6; i++) gap_tog("t4_idle");
      check("t4_count", 32'(match_count), 32'd1);
      do_abort();

      // 5: illegal lengths, error blocks start, legal write clears, frozen config
      do_cfg(8'h05, 4'd0, 1'b0, 8'd0);
      check("t5_err_len0", 32'(cfg_err), 32'd1);
      do_cfg(8'h05, 4'd9, 1'b0, 8'd0);
      check("t5_err_len9", 32'(cfg_err), 32'd1);
      do_start();
      check("t5_start_blocked", 32'(busy), 32'd0);
      do_cfg(8'h06, 4'd4, 1'b0, 8'd2);
      check("t5_err_clear", 32'(cfg_err), 32'd0);
      do_start();
      check("t5_busy", 32'(busy), 32'd1);
      do_cfg(8'h05, 4'd3, 1'b1, 8'd1);
      run_stream(16'b01100110, 16'b00010001, 8, "t5_frozen");
      check("t5_done",  32'(done),        32'd1);
      check("t5_count", 32'(match_count), 32'd2);
      do_abort();

      // 6a: abort on the completing bit
      do_cfg(8'h06, 4'd4, 1'b0, 8'd0);
      do_start();
      run_stream(16'b011, 16'b000, 3, "t6_pre");
      abort = 1'b1;
      send_bit(1'b0, 1'b0, "t6_abort_match");
      check("t6_abort_busy",  32'(busy),        32'd0);
      check("t6_abort_count", 32'(match_count), 32'd0);

      // 6b: reset mid-run restores outputs and default config
      do_cfg(8'h05, 4'd3, 1'b0, 8'd0);
      do_start();
      run_stream(16'b10, 16'b00, 2, "t6_pre2");
      reset = 1'b1;
      send_bit(1'b1, 1'b0, "t6_rst_match");
      reset = 1'b0;
      check("t6_rst_busy",  32'(busy),        32'd0);
      check("t6_rst_done",  32'(done),        32'd0);
      check("t6_rst_count", 32'(match_count), 32'd0);
      check("t6_rst_err",   32'(cfg_err),     32'd0);
      do_start();
      run_stream(16'b0110, 16'b0001, 4, "t6_defpat");
      do_abort();

      // 7: counter saturation with a 1-bit pattern matching every bit
      do_cfg(8'h01, 4'd1, 1'b1, 8'd0);
      do_start();
      in_valid = 1'b1;
      in       = 1'b1;
      repeat (260) tick();
      check("t7_sat_count", 32'(match_count), 32'd255);
      check("t7_sat_match", 32'(match),       32'd1);
      check("t7_sat_busy",  32'(busy),        32'd1);
      in_valid = 1'b0;
      do_abort();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_seq_detect_ctrl
